// File: rtl/bf_pkg.sv
// Shared types for the BF CPU data tape: command opcodes, tape FSM states, cell width.
package bf_pkg;

    localparam int unsigned CELL_W = 8;

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_PTR_INC = 2'd1,
        OP_PTR_DEC = 2'd2,
        OP_WRITE   = 2'd3
    } tape_op_e;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        READY = 2'd1,
        LOAD  = 2'd2
    } tape_state_e;

    // True for the opcodes that move the data pointer and therefore need a reload.
    function automatic logic is_move(input tape_op_e op);
        return (op == OP_PTR_INC) || (op == OP_PTR_DEC);
    endfunction

endpackage

// File: rtl/bf_tape_ram.sv
// Single-port cell RAM: synchronous write, one-cycle registered read, no reset
// (contents are initialised by the tape's clear sweep).
module bf_tape_ram
    import bf_pkg::*;
#(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [CELL_W-1:0] wdata,
    output logic [CELL_W-1:0] rdata
);

    logic [CELL_W-1:0] mem [DEPTH];

    // Read-before-write on a shared address; tape never relies on same-cycle write data here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bf_tape.sv
// BF CPU data tape: cell RAM, data pointer and cached current cell (cell_q).
// Optional macro BF_TAPE_BOUNDS_ERR_EN: saturate dp at the tape ends and raise sticky ptr_err.
module bf_tape
    import bf_pkg::*;
#(
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  tape_op_e          cmd_op,
    input  logic [CELL_W-1:0] wdata,
    output logic [CELL_W-1:0] cell_q,
    output logic              cell_zero,
    output logic [AW-1:0]     dp,
    output logic              ptr_err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    tape_state_e       state, state_next;
    logic [AW-1:0]     dp_next;
    logic [AW-1:0]     clr_addr, clr_addr_next;
    logic [CELL_W-1:0] cell_q_next;
    logic              ready_next;
    logic              err_next;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [CELL_W-1:0] ram_wdata;
    logic [CELL_W-1:0] ram_rdata;
    logic              accept;

    assign accept    = cmd_valid & cmd_ready;
    assign cell_zero = (cell_q == '0);

    bf_tape_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            dp        <= '0;
            clr_addr  <= '0;
            cell_q    <= '0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_next;
            dp        <= dp_next;
            clr_addr  <= clr_addr_next;
            cell_q    <= cell_q_next;
            cmd_ready <= ready_next;
        end
    end

`ifdef BF_TAPE_BOUNDS_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_next;
        end
    end

    assign ptr_err = err_q;
`else
    assign ptr_err = 1'b0;
`endif

    // Next-state, pointer arithmetic and RAM port control.
    always_comb begin
        state_next    = state;
        dp_next       = dp;
        clr_addr_next = clr_addr;
        cell_q_next   = cell_q;
        err_next      = ptr_err;
        ram_we        = 1'b0;
        ram_addr      = dp;
        ram_wdata     = '0;

        unique case (state)
            CLEAR: begin
                ram_we        = 1'b1;
                ram_addr      = clr_addr;
                clr_addr_next = clr_addr + AW'(1);
                if (clr_addr == LAST_ADDR) begin
                    state_next    = READY;
                    clr_addr_next = '0;
                end
            end
            READY: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            ram_we      = 1'b1;
                            ram_addr    = dp;
                            ram_wdata   = wdata;
                            cell_q_next = wdata;
                        end
                        OP_PTR_INC: begin
`ifdef BF_TAPE_BOUNDS_ERR_EN
                            if (dp == LAST_ADDR) begin
                                err_next = 1'b1;
                            end else begin
                                dp_next = dp + AW'(1);
                            end
`else
                            dp_next = dp + AW'(1);
`endif
                        end
                        OP_PTR_DEC: begin
`ifdef BF_TAPE_BOUNDS_ERR_EN
                            if (dp == '0) begin
                                err_next = 1'b1;
                            end else begin
                                dp_next = dp - AW'(1);
                            end
`else
                            dp_next = dp - AW'(1);
`endif
                        end
                        default: ;
                    endcase
                    // A move (even a blocked one) always reloads cell_q from the RAM.
                    if (is_move(cmd_op)) begin
                        ram_addr   = dp_next;
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                cell_q_next = ram_rdata;
                state_next  = READY;
            end
            default: begin
                state_next    = CLEAR;
                clr_addr_next = '0;
            end
        endcase

        ready_next = (state_next == READY);
    end

endmodule

// File: tb/tb_bf_tape.sv
// Directed self-checking bench for bf_tape (DEPTH=256); covers the
// BF_TAPE_BOUNDS_ERR_EN variant when that macro is defined.
module tb_bf_tape;
    import bf_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    tape_op_e          cmd_op;
    logic [CELL_W-1:0] wdata;
    logic [CELL_W-1:0] cell_q;
    logic              cell_zero;
    logic [AW-1:0]     dp;
    logic              ptr_err;

    int checks   = 0;
    int failures = 0;

    bf_tape #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .wdata     (wdata),
        .cell_q    (cell_q),
        .cell_zero (cell_zero),
        .dp        (dp),
        .ptr_err   (ptr_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!cmd_ready && w < 2*DEPTH + 8) begin
            tick();
            w++;
        end
        if (!cmd_ready) check_eq({tag, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic issue(input tape_op_e op, input logic [7:0] d);
        wait_ready("issue");
        cmd_valid = 1'b1;
        cmd_op    = op;
        wdata     = d;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        wdata     = 8'h00;
    endtask

    // Release reset and count edges until cmd_ready rises; expect exactly DEPTH.
    task automatic release_and_count(input string tag);
        int n = 0;
        rst = 1'b0;
        while (!cmd_ready && n < 4*DEPTH) begin
            tick();
            n++;
        end
        check_eq({tag, "_clear_cycles"}, 32'(n), 32'(DEPTH));
        check_eq({tag, "_dp"}, 32'(dp), 32'd0);
        check_eq({tag, "_cell_q"}, 32'(cell_q), 32'h00);
        check_eq({tag, "_cell_zero"}, 32'(cell_zero), 32'd1);
    endtask

    tape_op_e    hold_ops  [3];
    logic [7:0]  hold_data [3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nonzero;
        int idx;
        int cyc;
        logic acc;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        wdata     = 8'h00;
        repeat (3) tick();

        // 1: reset state, clear sweep length, all cells zero
        check_eq("rst_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_dp", 32'(dp), 32'd0);
        check_eq("rst_cell_q", 32'(cell_q), 32'h00);
        check_eq("rst_cell_zero", 32'(cell_zero), 32'd1);
        check_eq("rst_ptr_err", 32'(ptr_err), 32'd0);
        release_and_count("t1");
`ifndef BF_TAPE_BOUNDS_ERR_EN
        nonzero = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            issue(OP_PTR_INC, 8'h00);
            wait_ready("sweep");
            if (cell_q != 8'h00) nonzero++;
        end
        check_eq("t1_sweep_nonzero", 32'(nonzero), 32'd0);
        check_eq("t1_sweep_dp_wrapped", 32'(dp), 32'd0);
`endif

        // 2: write-through and readback across pointer moves
        issue(OP_WRITE, 8'hAD);
        check_eq("t2_write_cell_q", 32'(cell_q), 32'hAD);
        check_eq("t2_write_cell_zero", 32'(cell_zero), 32'd0);
        check_eq("t2_write_ready", 32'(cmd_ready), 32'd1);
        issue(OP_PTR_INC, 8'h00);
        check_eq("t2_load_ready_low", 32'(cmd_ready), 32'd0);
        issue(OP_WRITE, 8'hAC);
        issue(OP_PTR_DEC, 8'h00);
        wait_ready("t2");
        check_eq("t2_back_cell_q", 32'(cell_q), 32'hAD);
        check_eq("t2_back_dp", 32'(dp), 32'd0);
        issue(OP_PTR_INC, 8'h00);
        wait_ready("t2");
        check_eq("t2_fwd_cell_q", 32'(cell_q), 32'hAC);
        check_eq("t2_fwd_dp", 32'(dp), 32'd1);
        issue(OP_PTR_DEC, 8'h00);
        wait_ready("t2");

`ifndef BF_TAPE_BOUNDS_ERR_EN
        // 3: modulo wrap at both ends
        issue(OP_PTR_DEC, 8'h00);
        wait_ready("t3");
        check_eq("t3_wrap_dec_dp", 32'(dp), 32'(DEPTH - 1));
        check_eq("t3_wrap_dec_cell_q", 32'(cell_q), 32'h00);
        issue(OP_PTR_INC, 8'h00);
        wait_ready("t3");
        check_eq("t3_wrap_inc_dp", 32'(dp), 32'd0);
        check_eq("t3_wrap_inc_cell_q", 32'(cell_q), 32'hAD);
        check_eq("t3_ptr_err_tied", 32'(ptr_err), 32'd0);
`else
        // 6: bounds error saturates dp and is sticky until reset
        issue(OP_PTR_DEC, 8'h00);
        wait_ready("t6");
        check_eq("t6_dp_held", 32'(dp), 32'd0);
        check_eq("t6_ptr_err_set", 32'(ptr_err), 32'd1);
        check_eq("t6_cell_q_reload", 32'(cell_q), 32'hAD);
        issue(OP_PTR_INC, 8'h00);
        issue(OP_PTR_DEC, 8'h00);
        wait_ready("t6");
        check_eq("t6_ptr_err_sticky", 32'(ptr_err), 32'd1);
`endif

        // 4: cmd_valid held across ready-low cycles; only accepted ops count
        hold_ops[0] = OP_PTR_INC; hold_data[0] = 8'h00;
        hold_ops[1] = OP_PTR_INC; hold_data[1] = 8'h00;
        hold_ops[2] = OP_WRITE;   hold_data[2] = 8'h11;
        idx = 0;
        cyc = 0;
        cmd_valid = 1'b1;
        while (idx < 3 && cyc < 20) begin
            cmd_op = hold_ops[idx];
            wdata  = hold_data[idx];
            acc    = cmd_ready;
            tick();
            cyc++;
            if (acc) idx++;
            if (cyc == 4) check_eq("t4_dp_after_4", 32'(dp), 32'd2);
        end
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        check_eq("t4_total_cycles", 32'(cyc), 32'd5);
        check_eq("t4_dp", 32'(dp), 32'd2);
        check_eq("t4_cell_q", 32'(cell_q), 32'h11);
        issue(OP_PTR_DEC, 8'h00);
        wait_ready("t4");
        check_eq("t4_cell1_intact", 32'(cell_q), 32'hAC);
        issue(OP_PTR_INC, 8'h00);
        wait_ready("t4");
        check_eq("t4_cell2_landed", 32'(cell_q), 32'h11);

        // back-to-back writes on consecutive cycles
        issue(OP_PTR_INC, 8'h00);
        issue(OP_WRITE, 8'h55);
        issue(OP_WRITE, 8'h66);
        check_eq("b2b_cell_q", 32'(cell_q), 32'h66);
        issue(OP_NOP, 8'hFF);
        check_eq("nop_cell_q", 32'(cell_q), 32'h66);
        check_eq("nop_dp", 32'(dp), 32'd3);

        // 5: reset during LOAD restarts the clear sweep
        issue(OP_PTR_INC, 8'h00);
        check_eq("t5_in_load", 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_dp", 32'(dp), 32'd0);
        check_eq("t5_rst_cell_q", 32'(cell_q), 32'h00);
        check_eq("t5_rst_ptr_err", 32'(ptr_err), 32'd0);
        tick();
        release_and_count("t5");
        check_eq("t5_cell0_cleared", 32'(cell_q), 32'h00);
        issue(OP_PTR_INC, 8'h00);
        wait_ready("t5");
        check_eq("t5_cell1_cleared", 32'(cell_q), 32'h00);
        check_eq("t5_cell1_zero", 32'(cell_zero), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
